// File: rtl/patmos_io_shell.sv
// Board-boundary stand-in for the Patmos top: receives 8N1 UART bytes, shows the
// last good byte on the LEDs, echoes it on tx, and latches errors on led[8].
module patmos_io_shell #(
    parameter int CLK_FREQ = 80000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] io_cpuInfoPins_id,
    output logic [8:0]  io_ledsPins_led,
    output logic        io_uartPins_tx,
    input  logic        io_uartPins_rx,
    input  logic [1:0]  io_comConf_S_Resp,
    input  logic [1:0]  io_comSpm_S_Resp
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

    // The core ID is a reserved input with no influence on this shell.
    logic idUnused;
    assign idUnused = ^io_cpuInfoPins_id;

    logic             rxMeta_q, rxs_q, rxsPrev_q;
    rxState_t         rxState_q, rxState_d;
    logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]       rxBit_q, rxBit_d;
    logic [7:0]       rxShift_q, rxShift_d;
    logic             rxValid, rxFrameErr;

    logic [7:0]       ledByte_q, hold_q;
    logic             err_q, pending_q;

    txState_t         txState_q, txState_d;
    logic [CNT_W-1:0] txCnt_q, txCnt_d;
    logic [2:0]       txBit_q, txBit_d;
    logic [7:0]       txShift_q, txShift_d;
    logic             tx_q, tx_d, txLoad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxMeta_q  <= 1'b1;
            rxs_q     <= 1'b1;
            rxsPrev_q <= 1'b1;
        end else begin
            rxMeta_q  <= io_uartPins_rx;
            rxs_q     <= rxMeta_q;
            rxsPrev_q <= rxs_q;
        end
    end

    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q;
        rxBit_d    = rxBit_q;
        rxShift_d  = rxShift_q;
        rxValid    = 1'b0;
        rxFrameErr = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                rxCnt_d = '0;
                rxBit_d = '0;
                if (rxsPrev_q && !rxs_q) rxState_d = RX_START;
            end
            RX_START: begin
                if (rxCnt_q == HALF_LAST) begin
                    rxCnt_d   = '0;
                    rxState_d = rxs_q ? RX_IDLE : RX_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rxCnt_q == DIV_LAST) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxs_q, rxShift_q[7:1]};
                    rxBit_d   = rxBit_q + 1'b1;
                    if (rxBit_q == 3'd7) rxState_d = RX_STOP;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rxCnt_q == DIV_LAST) begin
                    rxCnt_d    = '0;
                    rxState_d  = RX_IDLE;
                    rxValid    = rxs_q;
                    rxFrameErr = !rxs_q;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
        end
    end

    // A fresh byte wins over the tx load in the same cycle, so it is never dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledByte_q <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (rxValid) begin
                ledByte_q <= rxShift_q;
                hold_q    <= rxShift_q;
                pending_q <= 1'b1;
            end else if (txLoad) begin
                pending_q <= 1'b0;
            end
            err_q <= err_q | rxFrameErr | (|io_comConf_S_Resp) | (|io_comSpm_S_Resp);
        end
    end

    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q;
        txBit_d   = txBit_q;
        txShift_d = txShift_q;
        txLoad    = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                if (pending_q) begin
                    txLoad    = 1'b1;
                    txState_d = TX_START;
                    txShift_d = hold_q;
                    txCnt_d   = '0;
                    txBit_d   = '0;
                end
            end
            TX_START: begin
                if (txCnt_q == DIV_LAST) begin
                    txCnt_d   = '0;
                    txState_d = TX_DATA;
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (txCnt_q == DIV_LAST) begin
                    txCnt_d   = '0;
                    txShift_d = {1'b1, txShift_q[7:1]};
                    txBit_d   = txBit_q + 1'b1;
                    if (txBit_q == 3'd7) txState_d = TX_STOP;
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (txCnt_q == DIV_LAST) begin
                    txCnt_d = '0;
                    if (pending_q) begin
                        txLoad    = 1'b1;
                        txState_d = TX_START;
                        txShift_d = hold_q;
                        txBit_d   = '0;
                    end else begin
                        txState_d = TX_IDLE;
                    end
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            default: txState_d = TX_IDLE;
        endcase
        case (txState_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = txShift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            txBit_q   <= txBit_d;
            txShift_q <= txShift_d;
            tx_q      <= tx_d;
        end
    end

    assign io_ledsPins_led = {err_q, ledByte_q};
    assign io_uartPins_tx  = tx_q;

endmodule

// File: tb/tb_patmos_io_shell.sv
// Directed bench for patmos_io_shell: UART receive/echo, glitch rejection,
// framing and response errors, back-to-back frames and reset behaviour.
`timescale 1ns/1ps
module tb_patmos_io_shell;

    localparam int  DIV    = 694;
    localparam real BIT_NS = 8681.0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] id = 32'h0;
    logic [8:0]  led;
    logic        tx;
    logic        rx = 1'b1;
    logic [1:0]  confResp = 2'b00;
    logic [1:0]  spmResp = 2'b00;

    int vectors = 0;
    int miscompares = 0;

    patmos_io_shell dut (
        .clk               (clk),
        .reset             (reset),
        .io_cpuInfoPins_id (id),
        .io_ledsPins_led   (led),
        .io_uartPins_tx    (tx),
        .io_uartPins_rx    (rx),
        .io_comConf_S_Resp (confResp),
        .io_comSpm_S_Resp  (spmResp)
    );

    always #6.25 clk = ~clk;

    task automatic resetDut();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(BIT_NS);
        end
        rx = stopBit;
        #(BIT_NS);
        rx = 1'b1;
    endtask

    // Waits (bounded) for a tx start bit, then samples each bit mid-period and
    // measures how long the line stays low from the start edge.
    task automatic captureTx(output logic [9:0] bits, output int lowRun, output bit ok);
        bit low;
        bits   = '0;
        lowRun = 0;
        ok     = 1'b0;
        for (int n = 0; n < 3 * 10 * DIV; n++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            low = 1'b1;
            for (int c = 0; c < 10 * DIV; c++) begin
                if (c != 0) @(negedge clk);
                if (c % DIV == DIV / 2) bits[c / DIV] = tx;
                if (low && tx === 1'b0) lowRun++;
                else low = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (led !== 9'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_led: got %h expected %h", led, 9'h000);
        end
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_tx: got %b expected 1", tx);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (led !== 9'h000 || tx !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL idle_quiet: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_valid_frame();
        logic [9:0] bits;
        int lowRun;
        bit ok;
        fork
            sendFrame(8'hAA, 1'b1);
            captureTx(bits, lowRun, ok);
        join
        vectors++;
        if (led !== 9'h0AA) begin
            miscompares++;
            $display("[TB] FAIL valid_led: got %h expected %h", led, 9'h0AA);
        end
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL valid_tx_timeout: got no start bit expected one");
        end
        vectors++;
        if (bits !== {1'b1, 8'hAA, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL valid_tx_bits: got %b expected %b", bits, {1'b1, 8'hAA, 1'b0});
        end
        vectors++;
        if (lowRun !== 2 * DIV) begin
            miscompares++;
            $display("[TB] FAIL valid_tx_width: got %0d expected %0d", lowRun, 2 * DIV);
        end
    endtask

    task automatic test_glitch();
        int bad;
        rx = 1'b0;
        #100;
        rx = 1'b1;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_tx: got %0d low cycles expected 0", bad);
        end
        vectors++;
        if (led !== 9'h0AA) begin
            miscompares++;
            $display("[TB] FAIL glitch_led: got %h expected %h", led, 9'h0AA);
        end
    endtask

    task automatic test_framing_error();
        int bad;
        bad = 0;
        fork
            sendFrame(8'h3C, 1'b0);
            for (int i = 0; i < 12 * DIV; i++) begin
                @(negedge clk);
                if (tx !== 1'b1) bad++;
            end
        join
        vectors++;
        if (led !== 9'h1AA) begin
            miscompares++;
            $display("[TB] FAIL frame_err_led: got %h expected %h", led, 9'h1AA);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL frame_err_tx: got %0d low cycles expected 0", bad);
        end
    endtask

    task automatic test_resp_error();
        int bad;
        resetDut();
        vectors++;
        if (led !== 9'h000) begin
            miscompares++;
            $display("[TB] FAIL resp_pre_led: got %h expected %h", led, 9'h000);
        end
        spmResp = 2'b01;
        @(negedge clk);
        spmResp = 2'b00;
        vectors++;
        if (led !== 9'h100) begin
            miscompares++;
            $display("[TB] FAIL spm_resp_led: got %h expected %h", led, 9'h100);
        end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (led !== 9'h100) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL spm_resp_sticky: got %0d bad cycles expected 0", bad);
        end
        resetDut();
        confResp = 2'b10;
        @(negedge clk);
        confResp = 2'b00;
        vectors++;
        if (led !== 9'h100) begin
            miscompares++;
            $display("[TB] FAIL conf_resp_led: got %h expected %h", led, 9'h100);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (led !== 9'h000) begin
            miscompares++;
            $display("[TB] FAIL async_reset_led: got %h expected %h", led, 9'h000);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits1, bits2;
        int lowRun1, lowRun2;
        bit ok1, ok2;
        logic [8:0] midLed;
        id = 32'hDEADBEEF;
        fork
            begin
                sendFrame(8'h55, 1'b1);
                midLed = led;
                sendFrame(8'hAA, 1'b1);
            end
            begin
                captureTx(bits1, lowRun1, ok1);
                captureTx(bits2, lowRun2, ok2);
            end
        join
        vectors++;
        if (midLed !== 9'h055) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_led: got %h expected %h", midLed, 9'h055);
        end
        vectors++;
        if (led !== 9'h0AA) begin
            miscompares++;
            $display("[TB] FAIL b2b_final_led: got %h expected %h", led, 9'h0AA);
        end
        vectors++;
        if (ok1 !== 1'b1 || bits1 !== {1'b1, 8'h55, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_tx_first: got ok=%b %b expected %b", ok1, bits1, {1'b1, 8'h55, 1'b0});
        end
        vectors++;
        if (lowRun1 !== DIV) begin
            miscompares++;
            $display("[TB] FAIL b2b_start_width: got %0d expected %0d", lowRun1, DIV);
        end
        vectors++;
        if (ok2 !== 1'b1 || bits2 !== {1'b1, 8'hAA, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_tx_second: got ok=%b %b expected %b", ok2, bits2, {1'b1, 8'hAA, 1'b0});
        end
        id = 32'h0;
    endtask

    task automatic test_reset_midframe();
        bit found;
        int bad;
        sendFrame(8'h0F, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 3 * DIV; n++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (found !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midframe_start: got no start bit expected one");
        end
        repeat (6 * DIV) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midframe_bit6: got %b expected 0", tx);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (tx !== 1'b1 || led !== 9'h000) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: got tx=%b led=%h expected tx=1 led=000", tx, led);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL midframe_after: got %0d low cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_glitch();
        test_framing_error();
        test_resp_error();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
